// File: rtl/mining_pkg.sv
// Shared types and defaults for the mining job dispatcher.
package mining_pkg;

  // Job lifecycle states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_FOUND = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } job_state_t;

  // Nonce / counter width used when the instantiator does not override it.
  localparam int DEFAULT_NONCE_W = 32;

  // Default watchdog budget between hashing results.
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/watchdog_timer.sv
// Cycle watchdog: counts enabled cycles since the last clear and flags
// expiry once the count reaches TIMEOUT_CYCLES-1.
module watchdog_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // At least one bit so tiny budgets still elaborate.
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Count enabled cycles; clear wins, and the count saturates at LAST.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable & (count == LAST);

endmodule

// File: rtl/mining_job_ctrl.sv
// Job dispatcher between the host registers and the hashing module.
// Tracks the hashing module's auto-incrementing nonce, counts completed
// hashes and ends a job on golden nonce, budget exhaustion, watchdog
// timeout or host abort. Results are held until the host acknowledges.
module mining_job_ctrl
  import mining_pkg::*;
#(
  parameter int NONCE_W        = DEFAULT_NONCE_W,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [NONCE_W-1:0] job_start_nonce,
  input  logic [NONCE_W-1:0] job_nonce_limit,
  input  logic               abort,
  input  logic               result_ack,
  output logic               begin_hash,
  output logic               quit_hash,
  input  logic               hash_done,
  input  logic               valid_hash,
  output logic [NONCE_W-1:0] cur_nonce,
  output logic [NONCE_W-1:0] hashes_tried,
  output logic               found,
  output logic [NONCE_W-1:0] found_nonce,
  output logic               exhausted,
  output logic               timeout_err,
  output logic               busy
);

  job_state_t         state;
  logic [NONCE_W-1:0] nonce_limit;
  logic               hash_done_q;
  logic               done_edge;
  logic               wd_expired;
  logic [NONCE_W-1:0] tried_inc;

  // Registered copy of hash_done so a held strobe produces a single edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hash_done_q <= 1'b0;
    end else begin
      hash_done_q <= hash_done;
    end
  end

  assign done_edge = hash_done & ~hash_done_q;
  assign tried_inc = hashes_tried + 1'b1;

  // Watchdog runs only while waiting for results; any result restarts it,
  // and leaving RUN (or passing through START) leaves it cleared.
  watchdog_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  ((state != ST_RUN) | done_edge),
    .enable (state == ST_RUN),
    .expired(wd_expired)
  );

  // Job FSM with counters; quit_hash is a registered one-cycle pulse that
  // lines up with the first cycle of the state it leads into.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= ST_IDLE;
      nonce_limit  <= '0;
      cur_nonce    <= '0;
      hashes_tried <= '0;
      found_nonce  <= '0;
      quit_hash    <= 1'b0;
    end else begin
      quit_hash <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (job_valid) begin
            cur_nonce    <= job_start_nonce;
            hashes_tried <= '0;
            nonce_limit  <= job_nonce_limit;
            // An empty budget completes immediately without touching the hasher.
            state        <= (job_nonce_limit == '0) ? ST_DONE : ST_START;
          end
        end
        ST_START: begin
          if (abort) begin
            quit_hash <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            quit_hash <= 1'b1;
            state     <= ST_IDLE;
          end else if (done_edge) begin
            if (valid_hash) begin
              // Golden nonce: freeze counters at the winning nonce.
              found_nonce <= cur_nonce;
              state       <= ST_FOUND;
            end else begin
              cur_nonce    <= cur_nonce + 1'b1;
              hashes_tried <= tried_inc;
              if (tried_inc == nonce_limit) begin
                quit_hash <= 1'b1;
                state     <= ST_DONE;
              end
            end
          end else if (wd_expired) begin
            quit_hash <= 1'b1;
            state     <= ST_ERROR;
          end
        end
        ST_FOUND: begin
          // The hasher keeps holding its golden result until told to stop.
          if (abort || result_ack) begin
            quit_hash <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_DONE, ST_ERROR: begin
          if (result_ack) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status outputs decode straight from the state register.
  assign job_ready   = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign begin_hash  = (state == ST_START);
  assign found       = (state == ST_FOUND);
  assign exhausted   = (state == ST_DONE);
  assign timeout_err = (state == ST_ERROR);

endmodule

// File: tb/tb_mining_job_ctrl.sv
// Self-checking bench for mining_job_ctrl: directed job table, corner-case
// sequences, and randomized jobs checked against a job-level outcome model.
module tb_mining_job_ctrl;

  logic        clk;
  logic        n_rst;
  logic        job_valid;
  logic        job_ready;
  logic [31:0] job_start_nonce;
  logic [31:0] job_nonce_limit;
  logic        abort;
  logic        result_ack;
  logic        begin_hash;
  logic        quit_hash;
  logic        hash_done;
  logic        valid_hash;
  logic [31:0] cur_nonce;
  logic [31:0] hashes_tried;
  logic        found;
  logic [31:0] found_nonce;
  logic        exhausted;
  logic        timeout_err;
  logic        busy;

  int checks;
  int errors;
  int cyc;
  int quit_cnt;
  int begin_cnt;

  mining_job_ctrl #(
    .NONCE_W       (32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .job_valid      (job_valid),
    .job_ready      (job_ready),
    .job_start_nonce(job_start_nonce),
    .job_nonce_limit(job_nonce_limit),
    .abort          (abort),
    .result_ack     (result_ack),
    .begin_hash     (begin_hash),
    .quit_hash      (quit_hash),
    .hash_done      (hash_done),
    .valid_hash     (valid_hash),
    .cur_nonce      (cur_nonce),
    .hashes_tried   (hashes_tried),
    .found          (found),
    .found_nonce    (found_nonce),
    .exhausted      (exhausted),
    .timeout_err    (timeout_err),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count and pulse counters sampled mid-cycle.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    quit_cnt  = 0;
    begin_cnt = 0;
  end
  always @(negedge clk) begin
    if (quit_hash)  quit_cnt  <= quit_cnt + 1;
    if (begin_hash) begin_cnt <= begin_cnt + 1;
  end

  // Hard stop in case the DUT wedges somewhere no bounded wait covers.
  initial begin
    #500000;
    $display("FAIL global_timeout actual=stuck required=finish");
    $fatal(1, "global timeout");
  end

  typedef struct {
    logic [31:0] start;
    logic [31:0] limit;
    int          golden;     // index of golden result, -1 for none
    logic        exp_found;
    logic [31:0] exp_fnonce;
    logic [31:0] exp_tried;
    logic [31:0] exp_cur;
    int          exp_quits;
    int          exp_begins;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Job-level outcome: the golden result ends the job if it falls inside
  // the budget, otherwise every nonce in the budget is tried.
  function automatic void model(input logic [31:0] start, input logic [31:0] limit,
                                input int golden, output logic f,
                                output logic [31:0] fn, output logic [31:0] tried,
                                output logic [31:0] cur, output int quits,
                                output int begins);
    f      = 1'b0;
    fn     = 32'h0;
    tried  = 32'h0;
    cur    = start;
    quits  = 0;
    begins = 0;
    if (limit != 0) begin
      begins = 1;
      quits  = 1;
      if (golden >= 0 && golden < int'(limit)) begin
        f     = 1'b1;
        fn    = start + 32'(golden);
        tried = 32'(golden);
        cur   = start + 32'(golden);
      end else begin
        tried = limit;
        cur   = start + limit;
      end
    end
  endfunction

  // Run one job: accept, feed result strobes, then acknowledge the outcome.
  task automatic run_job(input vec_t v, input int gap);
    int q0, b0, npulse;
    q0 = quit_cnt;
    b0 = begin_cnt;
    check("job_ready_idle", job_ready, 1);
    job_valid       = 1'b1;
    job_start_nonce = v.start;
    job_nonce_limit = v.limit;
    tick();
    job_valid = 1'b0;
    check("busy_accepted", busy, 1);
    if (v.limit != 0) begin
      check("begin_hash_start", begin_hash, 1);
      npulse = (v.golden >= 0 && v.golden < int'(v.limit)) ? v.golden + 1 : int'(v.limit);
      for (int i = 0; i < npulse; i++) begin
        repeat (gap) tick();
        hash_done  = 1'b1;
        valid_hash = (i == v.golden);
        tick();
        hash_done  = 1'b0;
        valid_hash = 1'b0;
        if (i != v.golden) check("cur_nonce_step", cur_nonce, v.start + 32'(i) + 32'd1);
      end
    end
    if (v.exp_found) begin
      check("found_flag", found, 1);
      check("found_nonce", found_nonce, v.exp_fnonce);
      check("tried_found", hashes_tried, v.exp_tried);
      check("cur_found", cur_nonce, v.exp_cur);
      check("no_quit_in_found", quit_cnt - q0, 0);
      result_ack = 1'b1;
      tick();
      result_ack = 1'b0;
      check("quit_after_ack", quit_hash, 1);
      check("ready_after_ack", job_ready, 1);
      check("found_cleared", found, 0);
    end else begin
      check("exhausted_flag", exhausted, 1);
      check("found_low", found, 0);
      check("tried_done", hashes_tried, v.exp_tried);
      check("cur_done", cur_nonce, v.exp_cur);
      check("quit_at_done", quit_hash, (v.exp_quits != 0) ? 1 : 0);
      result_ack = 1'b1;
      tick();
      result_ack = 1'b0;
      check("ready_after_ack", job_ready, 1);
      check("exhausted_cleared", exhausted, 0);
    end
    tick();
    check("quit_one_cycle", quit_hash, 0);
    check("quit_count", quit_cnt - q0, v.exp_quits);
    check("begin_count", begin_cnt - b0, v.exp_begins);
  endtask

  initial begin
    int   q0;
    int   b_cyc;
    int   waited;
    vec_t rv;

    checks          = 0;
    errors          = 0;
    n_rst           = 1'b0;
    job_valid       = 1'b0;
    job_start_nonce = '0;
    job_nonce_limit = '0;
    abort           = 1'b0;
    result_ack      = 1'b0;
    hash_done       = 1'b0;
    valid_hash      = 1'b0;

    vecs[0] = '{32'h0000_0100, 32'd10, 2,  1'b1, 32'h0000_0102, 32'd2, 32'h0000_0102, 1, 1};
    vecs[1] = '{32'hFFFF_FFFE, 32'd3,  -1, 1'b0, 32'h0,         32'd3, 32'h0000_0001, 1, 1};
    vecs[2] = '{32'h0000_0055, 32'd0,  -1, 1'b0, 32'h0,         32'd0, 32'h0000_0055, 0, 0};
    vecs[3] = '{32'h0000_0007, 32'd1,  0,  1'b1, 32'h0000_0007, 32'd0, 32'h0000_0007, 1, 1};
    vecs[4] = '{32'h0000_0020, 32'd1,  -1, 1'b0, 32'h0,         32'd1, 32'h0000_0021, 1, 1};
    vecs[5] = '{32'hFFFF_FFFF, 32'd4,  3,  1'b1, 32'h0000_0002, 32'd3, 32'h0000_0002, 1, 1};

    tick();
    tick();
    check("rst_job_ready", job_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_begin", begin_hash, 0);
    check("rst_quit", quit_hash, 0);
    check("rst_cur", cur_nonce, 0);
    check("rst_tried", hashes_tried, 0);
    check("rst_found", found, 0);
    check("rst_found_nonce", found_nonce, 0);
    check("rst_exhausted", exhausted, 0);
    check("rst_timeout", timeout_err, 0);
    n_rst = 1'b1;
    tick();

    // abort and result_ack in IDLE do nothing
    abort      = 1'b1;
    result_ack = 1'b1;
    tick();
    abort      = 1'b0;
    result_ack = 1'b0;
    check("idle_ignore_ready", job_ready, 1);
    tick();
    check("idle_ignore_quit", quit_hash, 0);

    for (int i = 0; i < 6; i++) run_job(vecs[i], 2);

    // Watchdog: no result after begin_hash; RUN lasts 16 cycles, then ERROR.
    q0              = quit_cnt;
    job_valid       = 1'b1;
    job_start_nonce = 32'h10;
    job_nonce_limit = 32'd5;
    tick();
    job_valid = 1'b0;
    b_cyc     = cyc;
    waited    = 0;
    while (!quit_hash && waited < 40) begin
      tick();
      waited++;
    end
    check("wd_quit_seen", quit_hash, 1);
    check("wd_latency", cyc - b_cyc, 17);
    check("wd_timeout_err", timeout_err, 1);
    check("wd_tried", hashes_tried, 0);
    tick();
    check("wd_quit_pulse", quit_cnt - q0, 1);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    check("wd_ack_ready", job_ready, 1);
    check("wd_err_cleared", timeout_err, 0);

    // Abort and golden edge together: abort wins, no result.
    q0              = quit_cnt;
    job_valid       = 1'b1;
    job_start_nonce = 32'h40;
    job_nonce_limit = 32'd10;
    tick();
    job_valid = 1'b0;
    tick();
    hash_done  = 1'b1;
    valid_hash = 1'b1;
    abort      = 1'b1;
    tick();
    abort      = 1'b0;
    hash_done  = 1'b0;
    valid_hash = 1'b0;
    check("abort_edge_ready", job_ready, 1);
    check("abort_edge_found", found, 0);
    check("abort_edge_quit", quit_hash, 1);
    tick();
    tick();
    check("abort_edge_quit_cnt", quit_cnt - q0, 1);

    // Held strobes count once, both invalid in RUN and golden in FOUND.
    q0              = quit_cnt;
    job_valid       = 1'b1;
    job_start_nonce = 32'h80;
    job_nonce_limit = 32'd10;
    tick();
    job_valid = 1'b0;
    tick();
    hash_done = 1'b1;
    repeat (5) tick();
    hash_done = 1'b0;
    check("held_invalid_tried", hashes_tried, 1);
    check("held_invalid_cur", cur_nonce, 32'h81);
    tick();
    hash_done  = 1'b1;
    valid_hash = 1'b1;
    tick();
    check("held_found", found, 1);
    repeat (20) tick();
    check("held_found_still", found, 1);
    check("held_found_nonce", found_nonce, 32'h81);
    check("held_found_tried", hashes_tried, 1);
    check("held_no_quit", quit_cnt - q0, 0);
    abort = 1'b1;
    tick();
    abort      = 1'b0;
    hash_done  = 1'b0;
    valid_hash = 1'b0;
    check("found_abort_ready", job_ready, 1);
    check("found_abort_found", found, 0);
    check("found_abort_quit", quit_hash, 1);
    tick();
    tick();
    check("found_abort_quit_cnt", quit_cnt - q0, 1);

    // Reset in the middle of RUN.
    q0              = quit_cnt;
    job_valid       = 1'b1;
    job_start_nonce = 32'h200;
    job_nonce_limit = 32'd10;
    tick();
    job_valid = 1'b0;
    tick();
    hash_done = 1'b1;
    tick();
    hash_done = 1'b0;
    check("pre_rst_tried", hashes_tried, 1);
    #2;
    n_rst = 1'b0;
    #1;
    check("mid_rst_ready", job_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cur", cur_nonce, 0);
    check("mid_rst_tried", hashes_tried, 0);
    check("mid_rst_quit", quit_hash, 0);
    tick();
    n_rst = 1'b1;
    tick();
    check("mid_rst_no_quit", quit_cnt - q0, 0);
    run_job(vecs[0], 1);

    // Randomized jobs against the outcome model.
    for (int n = 0; n < 30; n++) begin
      rv.start  = $urandom;
      rv.limit  = 32'($urandom_range(0, 6));
      rv.golden = int'($urandom_range(0, 7));
      model(rv.start, rv.limit, rv.golden, rv.exp_found, rv.exp_fnonce,
            rv.exp_tried, rv.exp_cur, rv.exp_quits, rv.exp_begins);
      $display("job %0d start=%h limit=%0d golden=%0d", n, rv.start, rv.limit, rv.golden);
      run_job(rv, int'($urandom_range(1, 6)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mining_job_ctrl.md
# mining_job_ctrl

Job dispatcher that drives the hashing module's `begin_hash`/`quit_hash` interface and consumes its `hash_done`/`valid_hash` results. It sits between the host register interface and the hashing module. Per job it mirrors the hashing module's auto-incrementing nonce, counts hashes tried, and stops on a golden nonce, on an exhausted nonce budget, on a watchdog timeout, or on host abort. It reports the outcome to the host and holds it until the host acknowledges.

## Interface
- `NONCE_W`, 32: nonce and counter width.
- `TIMEOUT_CYCLES`, 1024: maximum cycles allowed between `begin_hash` (or the previous `hash_done` edge) and the next `hash_done` rising edge.
- `clk`  in  1  clock.
- `n_rst`  in  1  reset; asynchronous, active-low.
- `job_valid`  in  1  host presents a job.
- `job_ready`  out  1  high only in IDLE; a job is accepted when `job_valid & job_ready`.
- `job_start_nonce`  in  NONCE_W  first nonce; sampled at acceptance.
- `job_nonce_limit`  in  NONCE_W  number of nonces to try; sampled at acceptance.
- `abort`  in  1  host cancels the active job.
- `result_ack`  in  1  host acknowledges FOUND, DONE or ERROR.
- `begin_hash`  out  1  one-cycle start pulse to the hashing module.
- `quit_hash`  out  1  one-cycle stop pulse to the hashing module.
- `hash_done`  in  1  hashing module result strobe; may stay high while it holds a golden hash.
- `valid_hash`  in  1  hash meets target; qualified by the `hash_done` rising edge.
- `cur_nonce`  out  NONCE_W  nonce currently being hashed.
- `hashes_tried`  out  NONCE_W  completed hashes in the current job.
- `found`, `found_nonce`  out  1, NONCE_W  golden nonce reported.
- `exhausted`  out  1  budget spent, no golden nonce found.
- `timeout_err`  out  1  watchdog expired.
- `busy`  out  1  not IDLE.

## Operation
States: IDLE, START, RUN, FOUND, DONE, ERROR.

- **IDLE**
  - `job_ready`=1.
  - On acceptance: load `cur_nonce`←`job_start_nonce`, clear `hashes_tried` and the watchdog.
  - If limit ≠ 0, go to START. If limit = 0, go to DONE without issuing `begin_hash`.
- **START**
  - `begin_hash`=1 for this single cycle.
  - Watchdog cleared. Next state RUN.
- **RUN**
  - The done edge is `hash_done & ~hash_done_q` (registered copy).
  - Edge with `valid_hash`=1: `found_nonce`←`cur_nonce`, go to FOUND. `cur_nonce` and `hashes_tried` are not advanced.
  - Edge with `valid_hash`=0: `cur_nonce`+1 (wraps modulo 2^NONCE_W), `hashes_tried`+1, watchdog cleared.
    - If `hashes_tried`+1 == limit: `quit_hash` pulse, go to DONE.
    - Otherwise stay in RUN. The hashing module restarts on its own; no new `begin_hash` is issued.
  - Watchdog reaches `TIMEOUT_CYCLES`−1 with no edge: `quit_hash` pulse, go to ERROR.
- **FOUND**
  - `found`=1.
  - On `result_ack`: `quit_hash` pulse, go to IDLE.
- **DONE**: `exhausted`=1; on `result_ack`, go to IDLE.
- **ERROR**: `timeout_err`=1; on `result_ack`, go to IDLE.
- **abort** in START, RUN or FOUND: `quit_hash` pulse, go to IDLE, no result flag set.
- **Priority** within one cycle: abort > done edge > watchdog.
- `result_ack` outside FOUND, DONE and ERROR is ignored. `abort` in IDLE is ignored.

## Timing
- Reset values: state IDLE; all outputs 0 except `job_ready`=1; `hash_done_q`=0.
- All outputs are registered or decoded from state only; there are no combinational input-to-output paths.
- Acceptance at edge N → `begin_hash` high during cycle N+1 → RUN from N+2.
- `quit_hash` is high exactly one cycle, in the cycle after the triggering edge. It coincides with the first cycle of the new state.
- The done edge is detected in the cycle after `hash_done` rises. A `hash_done` held high across cycles counts once.
- Counter updates and state changes occur on the same clock edge. `found_nonce` is stable for the whole FOUND state.
- Reset asserted mid-job returns to IDLE asynchronously with no `quit_hash` issued. The hashing module is reset by the same `n_rst`.

## Structure
- Shared package `mining_pkg`:
  - `job_state_t` enum.
  - `NONCE_W` default.
  - `DEFAULT_TIMEOUT_CYCLES` constant.
- Sub-module `watchdog_timer`:
  - Ports `clear`, `enable`, `expired`; parameter `TIMEOUT_CYCLES`.
  - Counter width `$clog2(TIMEOUT_CYCLES)`.
  - Enabled only in RUN.

## Test plan
- **Golden on third nonce:** start 0x100, limit 10; hash_done edges with valid 0, 0, 1 → `found_nonce`=0x102, `hashes_tried`=2. `result_ack` → one-cycle `quit_hash`, IDLE.
- **Budget exhaustion:** start 0xFFFF_FFFE, limit 3, all invalid → `cur_nonce` wraps 0xFFFF_FFFF→0x0 then 0x1. `quit_hash` after the third edge, `exhausted`=1, `hashes_tried`=3.
- **Limit 0:** → DONE directly, `begin_hash` never asserted.
- **Watchdog:** TIMEOUT_CYCLES=16, no `hash_done` after `begin_hash` → `quit_hash` 16 cycles later, `timeout_err`=1.
- **Simultaneous abort and done edge:** `abort` and a `valid_hash` edge in the same cycle → IDLE, `found`=0, one `quit_hash`. Repeat in FOUND with `hash_done` held high for 20 cycles → counted once.
- **Reset mid-RUN:** all outputs return to reset values; the next job works normally.
